// File: rtl/mx_pkg.sv
// Shared types and constants for the MX block-scaled accumulation path.
// E8M0 scales are pure biased exponents; the all-ones code marks NaN.
package mx_pkg;

    localparam int          E8M0_BIAS = 127;
    localparam logic [7:0]  E8M0_NAN  = 8'hFF;

    typedef logic [7:0] e8m0_t;

    typedef enum logic [1:0] {
        ACC,
        DRAIN,
        OUT
    } acc_state_e;

endpackage

// File: rtl/mx_scale_align.sv
// Combinational alignment of one block dot product into accumulator fixed point:
// shifts by 2^(sa+sb-254) relative to the accumulator LSB, saturating or flooring as needed.
module mx_scale_align
    import mx_pkg::*;
#(
    parameter int DP_WIDTH  = 21,
    parameter int ACC_WIDTH = 48,
    parameter int ACC_FRAC  = 16
)(
    input  logic signed [DP_WIDTH-1:0]  dp,
    input  e8m0_t                       scale_a,
    input  e8m0_t                       scale_b,
    output logic signed [ACC_WIDTH-1:0] term,
    output logic                        nan,
    output logic                        ovf
);

    localparam int EXT_W = ACC_WIDTH + DP_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [10:0]          sh;
    logic        [10:0]          rsh;
    logic signed [EXT_W-1:0]     ext;
    logic signed [EXT_W-1:0]     shl;
    logic signed [DP_WIDTH-1:0]  shr;
    logic        [DP_WIDTH:0]    hi;

    // The extended copy is wide enough that any left shift below ACC_WIDTH is lossless,
    // so representability reduces to checking that the bits above the sign all agree.
    always_comb begin
        sh   = $signed({3'b000, scale_a}) + $signed({3'b000, scale_b})
             - 11'(2 * E8M0_BIAS) + 11'(ACC_FRAC);
        rsh  = 11'(-sh);
        ext  = {{ACC_WIDTH{dp[DP_WIDTH-1]}}, dp};
        shl  = '0;
        shr  = '0;
        hi   = '0;
        term = '0;
        nan  = 1'b0;
        ovf  = 1'b0;

        if (scale_a == E8M0_NAN || scale_b == E8M0_NAN) begin
            nan = 1'b1;
        end else if (!sh[10]) begin
            if (sh >= 11'(ACC_WIDTH)) begin
                if (dp != '0) begin
                    ovf  = 1'b1;
                    term = dp[DP_WIDTH-1] ? ACC_MIN : ACC_MAX;
                end
            end else begin
                shl = ext <<< sh;
                hi  = shl[EXT_W-1:ACC_WIDTH-1];
                if ((&hi) || !(|hi)) begin
                    term = shl[ACC_WIDTH-1:0];
                end else begin
                    ovf  = 1'b1;
                    term = dp[DP_WIDTH-1] ? ACC_MIN : ACC_MAX;
                end
            end
        end else begin
            if (rsh >= 11'(DP_WIDTH)) begin
                term = {ACC_WIDTH{dp[DP_WIDTH-1]}};
            end else begin
                shr  = dp >>> rsh;
                term = {{(ACC_WIDTH-DP_WIDTH){shr[DP_WIDTH-1]}}, shr};
            end
        end
    end

endmodule

// File: rtl/mx_block_accum.sv
// Accumulates n_blocks scaled block dot products into one saturating fixed-point result
// per group, with valid/ready handshakes on both the term input and the result output.
module mx_block_accum
    import mx_pkg::*;
#(
    parameter int DP_WIDTH    = 21,
    parameter int SCALE_WIDTH = 8,
    parameter int N_BLOCKS    = 4,
    parameter int ACC_WIDTH   = 48,
    parameter int ACC_FRAC    = 16
)(
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic signed [DP_WIDTH-1:0]  i_dp,
    input  logic [SCALE_WIDTH-1:0]      i_scale_a,
    input  logic [SCALE_WIDTH-1:0]      i_scale_b,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [ACC_WIDTH-1:0] o_acc,
    output logic                        o_nan,
    output logic                        o_ovf
);

    localparam int CNT_W = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    acc_state_e                  state, state_nx;
    logic                        rst_done;
    logic                        accept, last_term;
    logic                        load_out, clear_acc;
    logic [CNT_W-1:0]            blk_cnt;

    logic signed [ACC_WIDTH-1:0] al_term;
    logic                        al_nan, al_ovf;

    logic                        s1_valid, s1_nan, s1_ovf;
    logic signed [ACC_WIDTH-1:0] s1_term;

    logic signed [ACC_WIDTH-1:0] acc, sum, acc_nx;
    logic                        nan_st, ovf_st, add_sat;

    assign accept    = i_valid && o_ready;
    assign last_term = (blk_cnt == CNT_W'(N_BLOCKS - 1));

    mx_scale_align #(
        .DP_WIDTH  (DP_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .ACC_FRAC  (ACC_FRAC)
    ) u_align (
        .dp      (i_dp),
        .scale_a (e8m0_t'(i_scale_a)),
        .scale_b (e8m0_t'(i_scale_b)),
        .term    (al_term),
        .nan     (al_nan),
        .ovf     (al_ovf)
    );

    // Holds o_ready low until the first clock edge after reset is released.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_done <= 1'b0;
        else          rst_done <= 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ACC;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ACC:     if (accept && last_term) state_nx = DRAIN;
            DRAIN:   state_nx = OUT;
            OUT:     if (o_valid && i_ready) state_nx = ACC;
            default: state_nx = ACC;
        endcase
    end

    // The first OUT cycle latches the finished sum; later OUT cycles wait for the handshake.
    always_comb begin
        o_ready   = 1'b0;
        load_out  = 1'b0;
        clear_acc = 1'b0;
        case (state)
            ACC:     o_ready = rst_done;
            OUT: begin
                load_out  = !o_valid;
                clear_acc = o_valid && i_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_term  <= '0;
            s1_nan   <= 1'b0;
            s1_ovf   <= 1'b0;
            blk_cnt  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_term <= al_term;
                s1_nan  <= al_nan;
                s1_ovf  <= al_ovf;
                blk_cnt <= last_term ? '0 : blk_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        sum     = acc + s1_term;
        add_sat = (acc[ACC_WIDTH-1] == s1_term[ACC_WIDTH-1]) &&
                  (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
        acc_nx  = add_sat ? (acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : sum;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc    <= '0;
            nan_st <= 1'b0;
            ovf_st <= 1'b0;
        end else if (clear_acc) begin
            acc    <= '0;
            nan_st <= 1'b0;
            ovf_st <= 1'b0;
        end else if (s1_valid) begin
            acc    <= acc_nx;
            nan_st <= nan_st | s1_nan;
            ovf_st <= ovf_st | s1_ovf | add_sat;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_acc   <= '0;
            o_nan   <= 1'b0;
            o_ovf   <= 1'b0;
        end else if (load_out) begin
            o_valid <= 1'b1;
            o_acc   <= acc;
            o_nan   <= nan_st;
            o_ovf   <= ovf_st;
        end else if (clear_acc) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mx_block_accum.sv
// Directed bench for mx_block_accum: hand-computed group sums, flags, latency,
// output back-pressure and mid-group reset.
module tb_mx_block_accum;

    logic               i_clk;
    logic               i_rst_n;
    logic               i_valid;
    logic               o_ready;
    logic signed [20:0] i_dp;
    logic [7:0]         i_scale_a;
    logic [7:0]         i_scale_b;
    logic               o_valid;
    logic               i_ready;
    logic signed [47:0] o_acc;
    logic               o_nan;
    logic               o_ovf;

    int vectors;
    int miscompares;

    mx_block_accum dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_dp      (i_dp),
        .i_scale_a (i_scale_a),
        .i_scale_b (i_scale_b),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_acc     (o_acc),
        .o_nan     (o_nan),
        .o_ovf     (o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [47:0] got, input logic [47:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one term and returns 1ns after the edge that accepted it.
    task automatic applyStimulus(input logic signed [20:0] dp, input logic [7:0] sa, input logic [7:0] sb);
        int waitCycles;
        waitCycles = 0;
        i_valid   = 1'b1;
        i_dp      = dp;
        i_scale_a = sa;
        i_scale_b = sb;
        @(negedge i_clk);
        while (!o_ready && waitCycles < 50) begin
            @(negedge i_clk);
            waitCycles++;
        end
        if (!o_ready) checkOutput("accept_timeout", 48'(o_ready), 48'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Called right after the last accept; expects o_valid exactly two edges later.
    task automatic checkResult(input string grp, input logic signed [47:0] expAcc,
                               input logic expNan, input logic expOvf);
        int n;
        n = 0;
        while (!o_valid && n < 20) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        checkOutput({grp, "_latency"}, 48'(n), 48'd2);
        checkOutput({grp, "_acc"}, o_acc, expAcc);
        checkOutput({grp, "_nan"}, 48'(o_nan), 48'(expNan));
        checkOutput({grp, "_ovf"}, 48'(o_ovf), 48'(expOvf));
        checkOutput({grp, "_ready_low"}, 48'(o_ready), 48'd0);
    endtask

    task automatic drainResult(input string grp);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        checkOutput({grp, "_valid_drop"}, 48'(o_valid), 48'd0);
        checkOutput({grp, "_ready_back"}, 48'(o_ready), 48'd1);
    endtask

    initial begin
        int sawValid;
        vectors     = 0;
        miscompares = 0;
        i_rst_n   = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        i_dp      = '0;
        i_scale_a = '0;
        i_scale_b = '0;

        #2;
        checkOutput("rst_valid", 48'(o_valid), 48'd0);
        checkOutput("rst_acc",   o_acc,        48'd0);
        checkOutput("rst_ready", 48'(o_ready), 48'd0);
        checkOutput("rst_nan",   48'(o_nan),   48'd0);
        checkOutput("rst_ovf",   48'(o_ovf),   48'd0);
        #20;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        checkOutput("post_rst_ready", 48'(o_ready), 48'd1);

        // 4 x 3 at unit scale: 12 << 16
        for (int i = 0; i < 4; i++) applyStimulus(21'sd3, 8'd127, 8'd127);
        checkResult("g1", 48'h0000_000C_0000, 1'b0, 1'b0);
        drainResult("g1");

        // shifts of -11, -11, +9, +16: 0 + -1 + -512 + 0
        applyStimulus(21'sd5,  8'd100, 8'd127);
        applyStimulus(-21'sd5, 8'd100, 8'd127);
        applyStimulus(-21'sd1, 8'd120, 8'd127);
        applyStimulus(21'sd0,  8'd127, 8'd127);
        checkResult("g2", 48'hFFFF_FFFF_FDFF, 1'b0, 1'b0);
        drainResult("g2");

        // second term NaN contributes zero but flags the group
        applyStimulus(21'sd1, 8'd127, 8'd127);
        applyStimulus(21'sd1, 8'hFF,  8'd127);
        applyStimulus(21'sd1, 8'd127, 8'd127);
        applyStimulus(21'sd1, 8'd127, 8'd127);
        checkResult("g3", 48'h0000_0003_0000, 1'b1, 1'b0);
        drainResult("g3");

        // huge positive shift saturates high; NaN flag must be cleared from g3
        applyStimulus(21'sd1048575, 8'd254, 8'd254);
        for (int i = 0; i < 3; i++) applyStimulus(21'sd0, 8'd127, 8'd127);
        checkResult("g4", 48'h7FFF_FFFF_FFFF, 1'b0, 1'b1);
        drainResult("g4");

        // saturates low, then adding -65536 must clamp at the minimum
        applyStimulus(-21'sd1048576, 8'd254, 8'd254);
        for (int i = 0; i < 3; i++) applyStimulus(-21'sd1, 8'd127, 8'd127);
        checkResult("g5", 48'h8000_0000_0000, 1'b0, 1'b1);
        drainResult("g5");

        // gaps between terms: 7<<16 - 2<<17 + (100>>1) - 3 = 196655
        applyStimulus(21'sd7, 8'd127, 8'd127);
        repeat (3) @(posedge i_clk);
        #1;
        applyStimulus(-21'sd2, 8'd127, 8'd128);
        repeat (2) @(posedge i_clk);
        #1;
        applyStimulus(21'sd100, 8'd127, 8'd110);
        applyStimulus(-21'sd3,  8'd127, 8'd111);
        checkResult("g6", 48'h0000_0003_002F, 1'b0, 1'b0);

        // back-pressure: junk input offered while result waits
        i_valid   = 1'b1;
        i_dp      = 21'sd1000;
        i_scale_a = 8'd127;
        i_scale_b = 8'd127;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk);
            #1;
            checkOutput("stall_valid", 48'(o_valid), 48'd1);
            checkOutput("stall_acc",   o_acc,        48'h0000_0003_002F);
            checkOutput("stall_ready", 48'(o_ready), 48'd0);
        end
        drainResult("g6");

        // reset after two accepted terms discards them and emits nothing
        applyStimulus(21'sd5, 8'd127, 8'd127);
        applyStimulus(21'sd5, 8'd127, 8'd127);
        #1;
        i_rst_n = 1'b0;
        #1;
        checkOutput("midrst_ready", 48'(o_ready), 48'd0);
        #1;
        i_rst_n = 1'b1;
        sawValid = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) sawValid = 1;
        end
        checkOutput("midrst_no_valid", 48'(sawValid), 48'd0);
        for (int i = 0; i < 4; i++) applyStimulus(21'sd2, 8'd127, 8'd127);
        checkResult("g7", 48'h0000_0008_0000, 1'b0, 1'b0);
        drainResult("g7");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
